// File: rtl/hex7seg_scan_if.sv
// Display-side bundle of the seven-segment scanner: nibble/dp load path,
// blanking control and the multiplexed segment/digit outputs.
interface hex7seg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] data_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  blank_en;
    logic [6:0]            seg_out;
    logic                  dp_out;
    logic [N_DIGITS-1:0]   dig_sel;
    logic                  frame_done;

    modport master (
        output data_in, dp_in, load, blank_en,
        input  seg_out, dp_out, dig_sel, frame_done
    );

    modport slave (
        input  data_in, dp_in, load, blank_en,
        output seg_out, dp_out, dig_sel, frame_done
    );
endinterface

// File: rtl/hex7seg_scan.sv
// Multiplexed N-digit hex seven-segment driver: shadow-latched nibbles, slot
// scan with one dead cycle per slot, leading-zero and global blanking.
module hex7seg_scan #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1,
    parameter int BLANK_LZ       = 1
) (
    input  logic           clk,
    input  logic           reset,
    hex7seg_scan_if.slave  bus
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] seg_drive(input logic [6:0] s);
        return (SEG_ACTIVE_LOW != 0) ? ~s : s;
    endfunction

    function automatic logic dp_drive(input logic d);
        return (SEG_ACTIVE_LOW != 0) ? ~d : d;
    endfunction

    function automatic logic [N_DIGITS-1:0] dig_drive(input logic [N_DIGITS-1:0] d);
        return (DIG_ACTIVE_LOW != 0) ? ~d : d;
    endfunction

    logic [4*N_DIGITS-1:0] shadow_data_p0;
    logic [N_DIGITS-1:0]   shadow_dp_p0;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;

    logic [N_DIGITS-1:0]   lz_mask;
    logic                  upper_zero;
    logic [N_DIGITS-1:0]   dig_onehot;
    logic                  digit_on;
    logic                  slot_last;
    logic                  frame_last;

    logic [6:0]            seg_p1;
    logic                  dp_p1;
    logic [N_DIGITS-1:0]   dig_p1;
    logic                  vld_p1;
    logic                  frame_p1;

    // Digit k is blank when it and every more-significant digit carry no nibble and no dp.
    always_comb begin
        lz_mask    = '0;
        upper_zero = 1'b1;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (shadow_data_p0[4*k +: 4] == 4'h0) && !shadow_dp_p0[k];
            lz_mask[k] = upper_zero && (BLANK_LZ != 0);
        end
    end

    always_comb begin
        dig_onehot      = '0;
        dig_onehot[idx] = 1'b1;
    end

    assign slot_last  = (cnt == CNT_LAST);
    assign frame_last = slot_last && (idx == IDX_LAST);
    // cnt == 0 is the anti-ghosting dead cycle at the start of every slot.
    assign digit_on   = !bus.blank_en && (cnt != '0) && !lz_mask[idx];

    // ---- stage p0: shadow registers and scan position ----
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_data_p0 <= '0;
            shadow_dp_p0   <= '0;
            cnt            <= '0;
            idx            <= '0;
            vld_p1         <= 1'b0;
            frame_p1       <= 1'b0;
        end else begin
            if (bus.load) begin
                shadow_data_p0 <= bus.data_in;
                shadow_dp_p0   <= bus.dp_in;
            end
            if (slot_last) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            vld_p1   <= digit_on;
            frame_p1 <= frame_last;
        end
    end

    // ---- stage p1: output register, qualified by vld_p1 ----
    always_ff @(posedge clk) begin
        seg_p1 <= decode(shadow_data_p0[4*idx +: 4]);
        dp_p1  <= shadow_dp_p0[idx];
        dig_p1 <= dig_onehot;
    end

    assign bus.seg_out    = seg_drive(vld_p1 ? seg_p1 : 7'h00);
    assign bus.dp_out     = dp_drive(vld_p1 && dp_p1);
    assign bus.dig_sel    = dig_drive(vld_p1 ? dig_p1 : '0);
    assign bus.frame_done = frame_p1;

endmodule

// File: tb/tb_hex7seg_scan.sv
// Bench for hex7seg_scan: table vectors, timing corner sequences and a random
// phase, all checked against a cycle-count based reference model.
module tb_hex7seg_scan;
    localparam int N  = 4;
    localparam int RD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hex7seg_scan_if #(.N_DIGITS(N)) b  ();
    hex7seg_scan_if #(.N_DIGITS(N)) b2 ();

    hex7seg_scan #(.N_DIGITS(N), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(1),
                   .DIG_ACTIVE_LOW(1), .BLANK_LZ(1))
        dut (.clk(clk), .reset(rst), .bus(b));

    hex7seg_scan #(.N_DIGITS(N), .REFRESH_DIV(RD), .SEG_ACTIVE_LOW(0),
                   .DIG_ACTIVE_LOW(0), .BLANK_LZ(1))
        dut_hi (.clk(clk), .reset(rst), .bus(b2));

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16];

    // Model state: ph counts non-reset edges since the last reset edge.
    int         ph = 0;
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0;
    int         obs_c = -1;
    int         obs_i = -1;
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_dig;
    logic       e_fd;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [27:0] segs;
        logic [3:0]  lit;
    } vec_t;
    vec_t vecs [6];

    function automatic logic [6:0] inv7(input logic [6:0] x);
        return ~x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_lit(input int i);
        int top = 0;
        for (int k = 0; k < N; k++)
            if (m_data[4*k +: 4] != 4'h0 || m_dp[k]) top = k;
        return i <= top;
    endfunction

    task automatic tick();
        int c, i;
        @(posedge clk);
        if (rst) begin
            e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF; e_fd = 1'b0;
            ph = 0; m_data = '0; m_dp = '0; obs_c = -1; obs_i = -1;
        end else begin
            c = ph % RD;
            i = (ph / RD) % N;
            e_fd = (c == RD - 1) && (i == N - 1);
            if (b.blank_en || c == 0 || !m_lit(i)) begin
                e_seg = 7'h7F; e_dp = 1'b1; e_dig = 4'hF;
            end else begin
                e_seg = inv7(seg_tab[m_data[4*i +: 4]]);
                e_dp  = !m_dp[i];
                e_dig = 4'hF;
                e_dig[i] = 1'b0;
            end
            obs_c = c;
            obs_i = i;
            ph++;
            if (b.load) begin
                m_data = b.data_in;
                m_dp   = b.dp_in;
            end
        end
        @(negedge clk);
        chk("model", {b.seg_out, b.dp_out, b.dig_sel, b.frame_done}, {e_seg, e_dp, e_dig, e_fd});
    endtask

    task automatic load_tick(input logic [15:0] d, input logic [3:0] p);
        b.data_in = d; b.dp_in = p; b.load = 1'b1;
        tick();
        b.load = 1'b0;
    endtask

    task automatic align(input int target);
        for (int k = 0; k < 40 && (ph % (N * RD)) != target; k++) tick();
        chk("align", ph % (N * RD), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ed;
        logic [6:0]  es;
        logic        edp;
        logic [15:0] rd;
        int          cnt_fd, cnt_lit;

        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs[0] = '{16'h12AF, 4'b0000, {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b1111};
        vecs[1] = '{16'h0005, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b0001};
        vecs[2] = '{16'h0000, 4'b0000, {7'h00, 7'h00, 7'h00, 7'h3F}, 4'b0001};
        vecs[3] = '{16'h0005, 4'b0100, {7'h00, 7'h3F, 7'h3F, 7'h6D}, 4'b0111};
        vecs[4] = '{16'h8000, 4'b0000, {7'h7F, 7'h3F, 7'h3F, 7'h3F}, 4'b1111};
        vecs[5] = '{16'h00C0, 4'b0001, {7'h00, 7'h00, 7'h39, 7'h3F}, 4'b0011};

        b.data_in = '0; b.dp_in = '0; b.load = 1'b0; b.blank_en = 1'b0;
        b2.data_in = '0; b2.dp_in = '0; b2.load = 1'b0; b2.blank_en = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        chk("reset_dig", b.dig_sel, 4'hF);
        chk("reset_seg", b.seg_out, 7'h7F);
        chk("reset_dp", b.dp_out, 1'b1);
        chk("reset_fd", b.frame_done, 1'b0);
        chk("reset_hi_seg", b2.seg_out, 7'h00);
        chk("reset_hi_dig", b2.dig_sel, 4'h0);
        rst = 1'b0;

        b2.data_in = 16'h0008; b2.load = 1'b1;
        for (int v = 0; v < 6; v++) begin
            load_tick(vecs[v].data, vecs[v].dp);
            b2.load = 1'b0;
            for (int t = 0; t < N * RD; t++) begin
                tick();
                if (obs_c == 2) begin
                    if (vecs[v].lit[obs_i]) begin
                        ed = 4'hF; ed[obs_i] = 1'b0;
                        es = inv7(vecs[v].segs[7*obs_i +: 7]);
                        edp = !vecs[v].dp[obs_i];
                    end else begin
                        ed = 4'hF; es = 7'h7F; edp = 1'b1;
                    end
                    chk($sformatf("vec%0d_dig%0d", v, obs_i),
                        {b.seg_out, b.dp_out, b.dig_sel}, {es, edp, ed});
                end
            end
        end

        cnt_fd = 0;
        for (int t = 0; t < 4 * N * RD; t++) begin
            tick();
            if (b.frame_done) cnt_fd++;
        end
        chk("frame_count", cnt_fd, 4);

        cnt_lit = 0;
        for (int t = 0; t < N * RD; t++) begin
            tick();
            if (b2.dig_sel != 4'h0) begin
                cnt_lit++;
                chk("hi_lit", {b2.seg_out, b2.dp_out, b2.dig_sel}, {7'h7F, 1'b0, 4'b0001});
            end else begin
                chk("hi_dark", {b2.seg_out, b2.dp_out}, {7'h00, 1'b0});
            end
        end
        chk("hi_lit_count", cnt_lit, 3);

        // Load mid-slot of digit 2: old glyph one more cycle, new glyph after.
        load_tick(16'h12AF, 4'b0000);
        tick();
        align(2 * RD + 1);
        load_tick(16'hFFFF, 4'b0000);
        chk("load_t1_seg", b.seg_out, inv7(7'h5B));
        tick();
        chk("load_t2_seg", b.seg_out, inv7(7'h71));
        chk("load_t2_dig", b.dig_sel, 4'b1011);

        b.blank_en = 1'b1;
        for (int t = 0; t < 10; t++) begin
            tick();
            chk("blank", {b.seg_out, b.dp_out, b.dig_sel}, {7'h7F, 1'b1, 4'hF});
        end
        b.blank_en = 1'b0;
        for (int t = 0; t < N * RD; t++) tick();

        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < N; k++) rd[4*k +: 4] = ($urandom % 2 != 0) ? 4'($urandom) : 4'h0;
            b.data_in  = rd;
            b.dp_in    = ($urandom % 8 == 0) ? 4'($urandom) : 4'h0;
            b.load     = ($urandom % 6 == 0);
            b.blank_en = ($urandom % 20 == 0);
            tick();
        end
        b.load = 1'b0; b.blank_en = 1'b0;

        // Reset right where frame_done would otherwise fire.
        load_tick(16'h12AF, 4'b0000);
        tick();
        align(N * RD - 1);
        rst = 1'b1;
        tick();
        chk("midrst_out", {b.seg_out, b.dp_out, b.dig_sel}, {7'h7F, 1'b1, 4'hF});
        chk("midrst_fd", b.frame_done, 1'b0);
        rst = 1'b0;
        tick();
        chk("midrst_dead", b.dig_sel, 4'hF);
        tick();
        chk("midrst_d0_dig", b.dig_sel, 4'b1110);
        chk("midrst_d0_seg", b.seg_out, inv7(7'h3F));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex7seg_scan.md
Name: hex7seg_scan

Overview:
Multiplexed N-digit hexadecimal seven-segment display driver. It latches a packed vector of 4-bit nibbles on a load strobe (e.g. the UART rx_ready pulse) and time-multiplexes the digits onto one shared segment bus with one-hot digit enables. It adds a refresh scan, inter-digit dead time, per-digit decimal points, leading-zero blanking and global blanking. It sits between the UART receive path and the board's common-anode or common-cathode display.

Parameters:
N_DIGITS, 4, number of digits scanned; legal range 1..8
REFRESH_DIV, 50000, clk cycles per digit slot including the dead cycle; must be >= 2
SEG_ACTIVE_LOW, 1, 1: seg_out and dp_out are driven low-active; 0: high-active
DIG_ACTIVE_LOW, 1, 1: dig_sel is low-active; 0: high-active
BLANK_LZ, 1, 1: leading-zero blanking is enabled; 0: all digits are always shown

Ports:
clk  in  1  system clock; the single clock domain
reset  in  1  synchronous, active-high reset
data_in  in  4*N_DIGITS  packed nibbles; [3:0] is digit 0 (least significant, rightmost)
dp_in  in  N_DIGITS  decimal-point request per digit, active-high
load  in  1  active-high; latches data_in and dp_in into the shadow registers
blank_en  in  1  active-high; forces all digits off
seg_out  out  7  segments {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
dp_out  out  1  decimal-point segment, polarity set by SEG_ACTIVE_LOW
dig_sel  out  N_DIGITS  one-hot digit enable, polarity set by DIG_ACTIVE_LOW
frame_done  out  1  one-cycle pulse when the last digit slot completes

Behaviour:
- Reset (synchronous, active-high):
  - Shadow data = 0; shadow dp = 0; cnt = 0; idx = 0.
  - seg_out, dp_out and dig_sel are all at their inactive level.
  - frame_done = 0.
  - Reset asserted mid-scan takes effect on the next clk edge; the scan restarts at digit 0 with a dead cycle.
- Load:
  - Each cycle with load=1 captures data_in and dp_in into the shadow registers.
  - Level-sensitive: holding load high reloads every cycle.
  - Shadow data captured at edge t is first visible on the outputs after edge t+1.
- Scan counter:
  - cnt counts 0..REFRESH_DIV-1.
  - At cnt = REFRESH_DIV-1: cnt returns to 0 and idx increments. idx wraps from N_DIGITS-1 to 0.
  - A load or blank_en never resets cnt or idx.
- frame_done:
  - Registered.
  - Asserted for exactly one cycle following the cycle where idx = N_DIGITS-1 and cnt = REFRESH_DIV-1.
- Output register (all outputs registered; each output reflects the previous cycle's state):
  - If blank_en = 1 or cnt = 0: dig_sel is all inactive and seg_out/dp_out are inactive. cnt = 0 gives one dead cycle per slot as an anti-ghosting guard.
  - Else if the digit at idx is lead-blanked: dig_sel is all inactive and seg_out/dp_out are inactive.
  - Else: dig_sel has only bit idx active; seg_out = decode(shadow[4*idx+:4]); dp_out = shadow dp[idx].
  - Net effect: each digit is lit for REFRESH_DIV-1 of every REFRESH_DIV cycles.
- Leading-zero blanking (BLANK_LZ = 1):
  - Digit k is blanked when k > 0 and every nibble at index >= k is 0 and every dp at index >= k is 0.
  - Digit 0 is never blanked. All-zero data displays a single "0".
- Decode table, active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - SEG_ACTIVE_LOW inverts all 7 bits and dp_out.
- N_DIGITS = 1: idx stays 0; frame_done pulses every REFRESH_DIV cycles.

Test Plan:
- Reset scan: N_DIGITS=4, REFRESH_DIV=4, active-low, load data_in=16'h12AF -> digit slots 0..3 show seg_out=~71, ~77, ~5B, ~06. dig_sel cycles 1110, 1101, 1011, 0111. Each digit is lit 3 cycles after 1 dead cycle (dig_sel=1111). frame_done pulses once per 16 cycles.
- Leading zeros: load 16'h0005 -> only digit 0 lit (seg_out=~6D); digits 1..3 keep dig_sel bit inactive. Load 16'h0000 -> digit 0 shows ~3F. Set dp_in=4'b0100 with 16'h0005 -> digits 0..2 lit, digit 1 shows ~3F.
- Load timing: assert load with 16'hFFFF mid-slot of digit 2 -> seg_out shows ~71 two edges after the load edge; cnt and idx are undisturbed.
- blank_en: assert for 10 cycles -> dig_sel=1111 and seg_out=7F throughout; on deassert, the scan resumes at the current idx/cnt without restart.
- Reset mid-scan: assert reset during digit 3 -> next edge all outputs inactive and frame_done=0. After release: 1 dead cycle, then digit 0 shows ~3F (shadow cleared).
- Polarity: SEG_ACTIVE_LOW=0, DIG_ACTIVE_LOW=0, data=4'h8 -> seg_out=7F and dig_sel=0001 during the lit slot; all zeros when inactive.
